// File: rtl/debug_pkg.sv
// debug_pkg: shared command codes and state encodings for the UART debug unit.
// The FSM state is one-hot so the state register itself can be exported as
// o_state without any decoding logic.
package debug_pkg;

   localparam int NB_CMD   = 8;
   localparam int NB_STATE = 11;

   // Command bytes accepted from the host while the unit is idle.
   localparam logic [NB_CMD-1:0] CMD_LOAD_IM   = 8'h01;
   localparam logic [NB_CMD-1:0] CMD_RUN       = 8'h02;
   localparam logic [NB_CMD-1:0] CMD_STEP_MODE = 8'h03;
   localparam logic [NB_CMD-1:0] CMD_DUMP_REG  = 8'h04;
   localparam logic [NB_CMD-1:0] CMD_DUMP_MEM  = 8'h05;
   localparam logic [NB_CMD-1:0] CMD_DUMP_PC   = 8'h06;
   localparam logic [NB_CMD-1:0] CMD_NSTEP     = 8'h07;

   // Sub-commands that are only meaningful inside step mode.
   localparam logic [NB_CMD-1:0] CMD_STEP      = 8'h08;
   localparam logic [NB_CMD-1:0] CMD_STEP_EXIT = 8'h0A;

   // One-hot controller states; bit position follows declaration order.
   typedef enum logic [NB_STATE-1:0] {
      ST_IDLE      = 11'b000_0000_0001,
      ST_IM_LOAD   = 11'b000_0000_0010,
      ST_RUN       = 11'b000_0000_0100,
      ST_STEP_WAIT = 11'b000_0000_1000,
      ST_STEP_EXEC = 11'b000_0001_0000,
      ST_NSTEP_ARG = 11'b000_0010_0000,
      ST_NSTEP_RUN = 11'b000_0100_0000,
      ST_DUMP_ADDR = 11'b000_1000_0000,
      ST_DUMP_LOAD = 11'b001_0000_0000,
      ST_DUMP_SEND = 11'b010_0000_0000,
      ST_DUMP_WAIT = 11'b100_0000_0000
   } state_t;

   // Which source a dump sequence is streaming out.
   typedef enum logic [1:0] {
      SRC_REG = 2'd0,
      SRC_MEM = 2'd1,
      SRC_PC  = 2'd2
   } dump_src_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// debug_tx_serializer: splits a captured CPU word into UART bytes, MSB first,
// and runs the start/done handshake with the transmitter. The controller only
// tells it when to load (DUMP_LOAD) and when it is waiting for a byte to finish
// (DUMP_WAIT); this block reports whether the finished byte was the word's last.
module debug_tx_serializer #(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               waiting,
   input  logic [NB_DATA-1:0] word,
   input  logic               tx_done_tick,
   output logic               tx_start,
   output logic [NB_BYTE-1:0] tx_data,
   output logic               byte_next,
   output logic               word_done
);

   localparam int BYTES = NB_DATA / NB_BYTE;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [NB_DATA-1:0] shreg;
   logic [IDX_W-1:0]   byte_idx;
   logic               last_byte;
   logic               accept;

   // A done tick only counts while the controller is actually waiting on one.
   assign last_byte = (byte_idx == IDX_W'(BYTES - 1));
   assign accept    = waiting & tx_done_tick;
   assign byte_next = accept & ~last_byte;
   assign word_done = accept & last_byte;

   // The byte on the line is always the top of the shift register, so it stays
   // put from the start pulse until the transmitter reports completion.
   assign tx_data = shreg[NB_DATA-1 -: NB_BYTE];

   // Capture the word, shift after each completed byte, pulse start for the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg    <= '0;
         byte_idx <= '0;
         tx_start <= 1'b0;
      end else begin
         tx_start <= load | byte_next;
         if (load) begin
            shreg    <= word;
            byte_idx <= '0;
         end else if (byte_next) begin
            shreg    <= shreg << NB_BYTE;
            byte_idx <= byte_idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/debug_unit_param.sv
// debug_unit_param: UART-side debug controller for the pipelined MIPS core.
// Decodes host command bytes, loads instruction memory word by word, gates the
// CPU clock-enable (free run, single step, N steps) and streams the PC, the
// register bank or data memory back out through the transmitter.
module debug_unit_param
   import debug_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int NB_BYTE     = 8,
   parameter int IM_DEPTH    = 64,
   parameter int NB_REG_ADDR = 5,
   parameter int DM_DEPTH    = 32,
   parameter int NB_ST       = 11
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [NB_BYTE-1:0]          i_rx_data,
   input  logic                        i_rx_done_tick,
   input  logic                        i_tx_done_tick,
   input  logic                        i_halt,
   input  logic [NB_DATA-1:0]          i_pc,
   input  logic [NB_DATA-1:0]          i_reg_data,
   input  logic [NB_DATA-1:0]          i_mem_data,
   output logic                        o_tx_start,
   output logic [NB_BYTE-1:0]          o_tx_data,
   output logic                        o_im_wr_en,
   output logic [$clog2(IM_DEPTH)-1:0] o_im_addr,
   output logic [NB_DATA-1:0]          o_im_data,
   output logic [NB_REG_ADDR-1:0]      o_reg_addr,
   output logic [$clog2(DM_DEPTH)-1:0] o_mem_addr,
   output logic                        o_cpu_enable,
   output logic [NB_ST-1:0]            o_state
);

   localparam int IM_AW = $clog2(IM_DEPTH);
   localparam int DM_AW = $clog2(DM_DEPTH);
   localparam int BYTES = NB_DATA / NB_BYTE;
   localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

   state_t             state;
   dump_src_t          dump_src;
   logic [BC_W-1:0]    byte_cnt;
   logic [NB_DATA-1:0] im_acc;
   logic [NB_BYTE-1:0] nstep_cnt;

   logic               im_word_last;
   logic               im_byte_last;
   logic [NB_DATA-1:0] im_word_next;
   logic               dump_word_last;
   logic [NB_DATA-1:0] dump_word;
   logic               ser_byte_next;
   logic               ser_word_done;

   assign o_state = NB_ST'(state);

   // Instruction word assembly: bytes arrive MSB first and shift in from the right.
   assign im_word_last = (o_im_addr == IM_AW'(IM_DEPTH - 1));
   assign im_byte_last = (byte_cnt == BC_W'(BYTES - 1));
   assign im_word_next = (im_acc << NB_BYTE) | NB_DATA'(i_rx_data);

   // Select the word being dumped and whether it is the final one of the sequence.
   always_comb begin
      dump_word      = i_pc;
      dump_word_last = 1'b1;
      case (dump_src)
         SRC_REG: begin
            dump_word      = i_reg_data;
            dump_word_last = (o_reg_addr == '1);
         end
         SRC_MEM: begin
            dump_word      = i_mem_data;
            dump_word_last = (o_mem_addr == DM_AW'(DM_DEPTH - 1));
         end
         default: begin
            dump_word      = i_pc;
            dump_word_last = 1'b1;
         end
      endcase
   end

   debug_tx_serializer #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_serializer (
      .clk          (i_clock),
      .rst_n        (i_reset),
      .load         (state == ST_DUMP_LOAD),
      .waiting      (state == ST_DUMP_WAIT),
      .word         (dump_word),
      .tx_done_tick (i_tx_done_tick),
      .tx_start     (o_tx_start),
      .tx_data      (o_tx_data),
      .byte_next    (ser_byte_next),
      .word_done    (ser_word_done)
   );

   // Main controller: command decode, IM loading, CPU gating and dump sequencing.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state        <= ST_IDLE;
         dump_src     <= SRC_REG;
         byte_cnt     <= '0;
         im_acc       <= '0;
         nstep_cnt    <= '0;
         o_im_wr_en   <= 1'b0;
         o_im_addr    <= '0;
         o_im_data    <= '0;
         o_reg_addr   <= '0;
         o_mem_addr   <= '0;
         o_cpu_enable <= 1'b0;
      end else begin
         o_im_wr_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_rx_done_tick) begin
                  case (i_rx_data)
                     NB_BYTE'(CMD_LOAD_IM): begin
                        state     <= ST_IM_LOAD;
                        o_im_addr <= '0;
                        byte_cnt  <= '0;
                        im_acc    <= '0;
                     end
                     NB_BYTE'(CMD_RUN): begin
                        state        <= ST_RUN;
                        o_cpu_enable <= 1'b1;
                     end
                     NB_BYTE'(CMD_STEP_MODE): begin
                        state <= ST_STEP_WAIT;
                     end
                     NB_BYTE'(CMD_DUMP_REG): begin
                        state      <= ST_DUMP_ADDR;
                        dump_src   <= SRC_REG;
                        o_reg_addr <= '0;
                     end
                     NB_BYTE'(CMD_DUMP_MEM): begin
                        state      <= ST_DUMP_ADDR;
                        dump_src   <= SRC_MEM;
                        o_mem_addr <= '0;
                     end
                     NB_BYTE'(CMD_DUMP_PC): begin
                        state    <= ST_DUMP_ADDR;
                        dump_src <= SRC_PC;
                     end
                     NB_BYTE'(CMD_NSTEP): begin
                        state <= ST_NSTEP_ARG;
                     end
                     default: begin
                        state <= ST_IDLE;
                     end
                  endcase
               end
            end

            ST_IM_LOAD: begin
               if (o_im_wr_en && im_word_last) begin
                  state <= ST_IDLE;
               end else begin
                  if (o_im_wr_en) begin
                     o_im_addr <= o_im_addr + IM_AW'(1);
                  end
                  if (i_rx_done_tick) begin
                     if (im_byte_last) begin
                        o_im_data  <= im_word_next;
                        o_im_wr_en <= 1'b1;
                        byte_cnt   <= '0;
                     end else begin
                        im_acc   <= im_word_next;
                        byte_cnt <= byte_cnt + BC_W'(1);
                     end
                  end
               end
            end

            ST_RUN: begin
               if (i_halt) begin
                  state        <= ST_IDLE;
                  o_cpu_enable <= 1'b0;
               end
            end

            ST_STEP_WAIT: begin
               if (i_halt) begin
                  state <= ST_IDLE;
               end else if (i_rx_done_tick) begin
                  if (i_rx_data == NB_BYTE'(CMD_STEP)) begin
                     state        <= ST_STEP_EXEC;
                     o_cpu_enable <= 1'b1;
                  end else if (i_rx_data == NB_BYTE'(CMD_STEP_EXIT)) begin
                     state <= ST_IDLE;
                  end
               end
            end

            ST_STEP_EXEC: begin
               state        <= ST_STEP_WAIT;
               o_cpu_enable <= 1'b0;
            end

            ST_NSTEP_ARG: begin
               if (i_rx_done_tick) begin
                  if (i_rx_data == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     state        <= ST_NSTEP_RUN;
                     o_cpu_enable <= 1'b1;
                     nstep_cnt    <= i_rx_data - NB_BYTE'(1);
                  end
               end
            end

            ST_NSTEP_RUN: begin
               if (i_halt || nstep_cnt == '0) begin
                  state        <= ST_IDLE;
                  o_cpu_enable <= 1'b0;
               end else begin
                  nstep_cnt <= nstep_cnt - NB_BYTE'(1);
               end
            end

            ST_DUMP_ADDR: begin
               state <= ST_DUMP_LOAD;
            end

            ST_DUMP_LOAD: begin
               state <= ST_DUMP_SEND;
            end

            ST_DUMP_SEND: begin
               state <= ST_DUMP_WAIT;
            end

            ST_DUMP_WAIT: begin
               if (ser_byte_next) begin
                  state <= ST_DUMP_SEND;
               end else if (ser_word_done) begin
                  if (dump_word_last) begin
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_DUMP_ADDR;
                     if (dump_src == SRC_REG) begin
                        o_reg_addr <= o_reg_addr + NB_REG_ADDR'(1);
                     end else if (dump_src == SRC_MEM) begin
                        o_mem_addr <= o_mem_addr + DM_AW'(1);
                     end
                  end
               end
            end

            default: begin
               state        <= ST_IDLE;
               o_cpu_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule
